// File: rtl/bcd_pkg.sv
// Shared constants, digit type and FSM state type for the BCD/Excess-3 serial converter.
package bcd_pkg;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] XS3_MIN    = 4'd3;
  localparam logic [3:0] XS3_MAX    = 4'd12;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_xs3_digit.sv
// Single-digit combinational converter: BCD->XS3 (mode=0) or XS3->BCD (mode=1), mod-16 with validity flag.
module bcd_xs3_digit
  import bcd_pkg::*;
(
  input  digit_t digit_in,
  input  logic   mode,
  output digit_t digit_out,
  output logic   err
);

  // Out-of-range codes still wrap mod 16; only err tells them apart.
  always_comb begin
    digit_out = digit_in + XS3_OFFSET;
    err       = (digit_in > BCD_MAX);
    if (mode) begin
      digit_out = digit_in - XS3_OFFSET;
      err       = (digit_in < XS3_MIN) || (digit_in > XS3_MAX);
    end
  end

endmodule

// File: rtl/bcd_xs3_serial_converter.sv
// Serial multi-digit BCD->Excess-3 converter, one digit per clock, LSD first, valid/ready on both sides.
// Optional XS3_DECODE_EN adds a mode input (1 = Excess-3 -> BCD decode) and an out_mode echo.
module bcd_xs3_serial_converter
  import bcd_pkg::*;
#(
  parameter  int DIGITS = 4,
  localparam int DW     = 4 * DIGITS,
  localparam int IDXW   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_bcd,
`ifdef XS3_DECODE_EN
  input  logic              mode,
  output logic              out_mode,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_xs3,
  output logic [DIGITS-1:0] out_err_mask,
  output logic              out_err,
  output logic              busy
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  state_t              state_q, state_d;
  logic [IDXW-1:0]     idx_q;
  logic [DW-1:0]       shift_q;
  logic [DW-1:0]       work_q, work_nxt;
  logic [DIGITS-1:0]   errw_q, errw_nxt;
  logic [DW-1:0]       xs3_q;
  logic [DIGITS-1:0]   mask_q;
  logic                mode_w;
  logic                accept;
  logic                last;
  digit_t              dig_out;
  logic                dig_err;

`ifdef XS3_DECODE_EN
  logic mode_q;
  assign mode_w   = mode_q;
  assign out_mode = mode_q;
`else
  assign mode_w = 1'b0;
`endif

  assign accept = (state_q == IDLE) && in_valid;
  assign last   = (idx_q == LAST_IDX);

  bcd_xs3_digit u_digit (
    .digit_in  (shift_q[3:0]),
    .mode      (mode_w),
    .digit_out (dig_out),
    .err       (dig_err)
  );

  // Merge the converted digit into the working word at the current index.
  always_comb begin
    work_nxt = work_q;
    errw_nxt = errw_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDXW'(i)) begin
        work_nxt[4*i +: 4] = dig_out;
        errw_nxt[i]        = dig_err;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CONV;
      CONV:    if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and visible output registers: cleared by reset so an abort leaks no partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      xs3_q   <= '0;
      mask_q  <= '0;
`ifdef XS3_DECODE_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q  <= '0;
`ifdef XS3_DECODE_EN
        mode_q <= mode;
`endif
      end else if (state_q == CONV) begin
        idx_q <= last ? '0 : idx_q + 1'b1;
        if (last) begin
          xs3_q  <= work_nxt;
          mask_q <= errw_nxt;
        end
      end
    end
  end

  // Working datapath: no reset needed, every word reloads it on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      shift_q <= in_bcd;
      work_q  <= '0;
      errw_q  <= '0;
    end else if (state_q == CONV) begin
      shift_q <= shift_q >> 4;
      work_q  <= work_nxt;
      errw_q  <= errw_nxt;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign out_xs3      = xs3_q;
  assign out_err_mask = mask_q;
  assign out_err      = |mask_q;

endmodule

// File: tb/tb_bcd_xs3_serial_converter.sv
// Self-checking bench for bcd_xs3_serial_converter: directed cases plus random words against an arithmetic model.
module tb_bcd_xs3_serial_converter;

  localparam int DIGITS = 4;
  localparam int DW     = 4 * DIGITS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     in_bcd = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     out_xs3;
  logic [DIGITS-1:0] out_err_mask;
  logic              out_err;
  logic              busy;
`ifdef XS3_DECODE_EN
  logic              mode = 1'b0;
  logic              out_mode;
`endif

  int total  = 0;
  int passed = 0;
  int failed = 0;

  bcd_xs3_serial_converter #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_bcd       (in_bcd),
`ifdef XS3_DECODE_EN
    .mode         (mode),
    .out_mode     (out_mode),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_xs3      (out_xs3),
    .out_err_mask (out_err_mask),
    .out_err      (out_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Reference: each nibble treated as an integer 0..15, offset by +3 (or -3) modulo 16.
  function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] w, input bit dec);
    logic [DW-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      int d = (w >> (4 * i)) % 16;
      int v = dec ? (d + 13) % 16 : (d + 3) % 16;
      r = r | (DW'(v) << (4 * i));
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] ref_mask(input logic [DW-1:0] w, input bit dec);
    logic [DIGITS-1:0] m = '0;
    for (int i = 0; i < DIGITS; i++) begin
      int d = (w >> (4 * i)) % 16;
      m[i] = dec ? (d < 3 || d > 12) : (d > 9);
    end
    return m;
  endfunction

  task automatic run_word(input logic [DW-1:0] w, input bit dec, input int hold);
    logic [DW-1:0]     ex = ref_word(w, dec);
    logic [DIGITS-1:0] em = ref_mask(w, dec);
    int n = 0;
    int lat = 0;
    in_bcd   = w;
    in_valid = 1'b1;
`ifdef XS3_DECODE_EN
    mode = dec;
`endif
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("in_ready_timeout", 64'd0, 64'd1);
    tick();
    in_valid = 1'b0;
    in_bcd   = $urandom;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(DIGITS));
    check("done_busy", 64'(busy), 64'd1);
    check("done_in_ready", 64'(in_ready), 64'd0);
    repeat (hold) tick();
    check("out_xs3", 64'(out_xs3), 64'(ex));
    check("out_err_mask", 64'(out_err_mask), 64'(em));
    check("out_err", 64'(out_err), 64'(|em));
`ifdef XS3_DECODE_EN
    check("out_mode", 64'(out_mode), 64'(dec));
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_hs_valid", 64'(out_valid), 64'd0);
    check("post_hs_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [DW-1:0] held;
    logic [DW-1:0] w;
    int            guard;

    // Reset state
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_xs3", 64'(out_xs3), 64'd0);
    check("rst_mask", 64'(out_err_mask), 64'd0);
    check("rst_err", 64'(out_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Directed words; outputs hold after the handshake so constants are checked afterwards
    run_word(16'h1234, 1'b0, 0);
    check("c_1234", 64'(out_xs3), 64'h4567);
    run_word(16'h9870, 1'b0, 1);
    check("c_9870", 64'(out_xs3), 64'hCBA3);
    run_word(16'h0000, 1'b0, 0);
    check("c_0000", 64'(out_xs3), 64'h3333);
    check("c_0000_mask", 64'(out_err_mask), 64'h0);
    run_word(16'hF9A0, 1'b0, 2);
    check("c_F9A0", 64'(out_xs3), 64'h2CD3);
    check("c_F9A0_mask", 64'(out_err_mask), 64'b1010);
    check("c_F9A0_err", 64'(out_err), 64'd1);

    // Backpressure: hold DONE for 10 cycles while a second word waits
    in_bcd   = 16'h2468;
    in_valid = 1'b1;
    tick();
    in_bcd   = 16'h1357;
    guard = 0;
    while (!out_valid && guard < 40) begin
      tick();
      guard++;
    end
    check("bp_reach_done", 64'(out_valid), 64'd1);
    held = out_xs3;
    check("bp_first", 64'(held), 64'(ref_word(16'h2468, 1'b0)));
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 9) begin
        check("bp_stable", 64'(out_xs3), 64'(held));
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_still_valid", 64'(out_valid), 64'd1);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_one_hs", 64'(out_valid), 64'd0);
    check("bp_idle_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_second_accepted", 64'(busy), 64'd1);
    guard = 0;
    while (!out_valid && guard < 40) begin
      tick();
      guard++;
    end
    check("bp_second", 64'(out_xs3), 64'(ref_word(16'h1357, 1'b0)));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of CONV
    in_bcd   = 16'h1234;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_xs3", 64'(out_xs3), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_mask", 64'(out_err_mask), 64'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    run_word(16'h0005, 1'b0, 0);
    check("c_0005", 64'(out_xs3), 64'h3338);

`ifdef XS3_DECODE_EN
    run_word(16'h4567, 1'b1, 0);
    check("dec_4567", 64'(out_xs3), 64'h1234);
    run_word(16'h0F33, 1'b1, 1);
    check("dec_0F33_mask", 64'(out_err_mask), 64'b1100);
    check("dec_out_mode", 64'(out_mode), 64'd1);
`endif

    // Random words with random consumer stall
    for (int k = 0; k < 25; k++) begin
      w = DW'($urandom);
`ifdef XS3_DECODE_EN
      run_word(w, bit'($urandom_range(0, 1)), $urandom_range(0, 3));
`else
      run_word(w, 1'b0, $urandom_range(0, 3));
`endif
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
